// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources, with packet lock
// and power gating of the baud-clock generator (warm-up before first byte, shut-off when idle).
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned WARMUP_CYC = 4,
   parameter int unsigned IDLE_CYC   = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_valid,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_ready,
   output logic                       uart_en,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);
   localparam int unsigned WC_W = $clog2(WARMUP_CYC) + 1;
   localparam int unsigned IC_W = $clog2(IDLE_CYC) + 1;

   localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);
   localparam logic [WC_W-1:0] WARM_END = WC_W'(WARMUP_CYC - 1);
   localparam logic [IC_W-1:0] IDLE_END = IC_W'(IDLE_CYC - 1);

   typedef enum logic [1:0] {StOff, StWarm, StArb, StXfer} state_e;

   state_e            state_q, state_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic [IC_W-1:0]   icnt_q, icnt_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic              lock_q, lock_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;

   logic [ID_W-1:0] rr_pick, cand, win;
   logic            rr_found, win_ok, grant;

   // First valid requester strictly after the round-robin pointer, wrapping.
   always_comb begin
      rr_pick  = rr_q;
      rr_found = 1'b0;
      cand     = rr_q;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
         if (!rr_found && req_valid[cand]) begin
            rr_found = 1'b1;
            rr_pick  = cand;
         end
      end
   end

   // While locked only the packet owner may be granted.
   assign win    = lock_q ? grant_q : rr_pick;
   assign win_ok = lock_q ? req_valid[grant_q] : rr_found;
   assign grant  = (state_q == StArb) && win_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StOff;
         wcnt_q  <= '0;
         icnt_q  <= '0;
         rr_q    <= LAST_ID;
         grant_q <= '0;
         lock_q  <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         icnt_q  <= icnt_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         lock_q  <= lock_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      icnt_d  = icnt_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      lock_d  = lock_q;
      data_d  = data_q;
      last_d  = last_q;
      unique case (state_q)
         StOff: begin
            if (|req_valid) begin
               state_d = StWarm;
               wcnt_d  = '0;
            end
         end
         StWarm: begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == WARM_END) begin
               state_d = StArb;
               icnt_d  = '0;
            end
         end
         StArb: begin
            if (grant) begin
               state_d = StXfer;
               grant_d = win;
               rr_d    = win;
               icnt_d  = '0;
               data_d  = DATA_W'(req_data >> (32'(win) * DATA_W));
               last_d  = req_last[win];
            end else if (!lock_q) begin
               if (icnt_q == IDLE_END) begin
                  state_d = StOff;
                  icnt_d  = '0;
               end else begin
                  icnt_d = icnt_q + 1'b1;
               end
            end
         end
         StXfer: begin
            if (tx_ready) begin
               state_d = StArb;
               lock_d  = ~last_q;
            end
         end
         default: state_d = StOff;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[win] = 1'b1;
      end
      tx_valid = (state_q == StXfer);
      tx_data  = data_q;
      uart_en  = (state_q != StOff);
      busy     = (state_q != StOff);
      grant_id = grant_q;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic checked against a
// transaction-level round-robin/lock model and an in-order byte scoreboard.
module tb_uart_tx_arbiter;

   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned WARMUP_CYC = 4;
   localparam int unsigned IDLE_CYC   = 16;
   localparam int unsigned ID_W       = $clog2(NUM_REQ);
   localparam int unsigned BW         = DATA_W + 1;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        req_last = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      tx_valid;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_ready = 1'b0;
   logic                      uart_en;
   logic [ID_W-1:0]           grant_id;
   logic                      busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .WARMUP_CYC(WARMUP_CYC),
      .IDLE_CYC  (IDLE_CYC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_last (req_last),
      .req_ready(req_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .uart_en  (uart_en),
      .grant_id (grant_id),
      .busy     (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Byte sources: each requester replays its {last,data} list in order.
   logic [BW-1:0] src_mem [NUM_REQ][64];
   int unsigned   src_len [NUM_REQ];
   int unsigned   src_pos [NUM_REQ];
   int unsigned   vprob  = 100;
   int unsigned   txprob = 100;

   task automatic src_clear();
      for (int i = 0; i < NUM_REQ; i++) begin
         src_len[i] = 0;
         src_pos[i] = 0;
      end
   endtask

   task automatic src_push(input int i, input logic [DATA_W-1:0] d, input logic l);
      src_mem[i][src_len[i]] = {l, d};
      src_len[i]++;
   endtask

   // Reference model state.
   int unsigned        m_rr;
   int unsigned        m_owner;
   bit                 m_lock;
   logic [BW-1:0]      sb[$];
   int unsigned        acc_ids[$];
   int                 n_sent = 0;
   bit                 pend_lat, stall_prev;
   logic [DATA_W-1:0]  td_prev;
   logic [NUM_REQ-1:0] rr_prev, acc;

   logic [NUM_REQ-1:0] s_rr;
   logic               s_tv, s_en, s_hs;
   logic [DATA_W-1:0]  s_td;

   function automatic int unsigned pick(input logic [NUM_REQ-1:0] v);
      if (m_lock) return m_owner;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         int unsigned idx;
         idx = (m_rr + k) % NUM_REQ;
         if (v[idx]) return idx;
      end
      return m_rr;
   endfunction

   task automatic drive();
      logic [BW-1:0] b;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_pos[i] < src_len[i] && $urandom_range(99) < vprob) begin
            req_valid[i] = 1'b1;
            b = src_mem[i][src_pos[i]];
         end else begin
            req_valid[i] = 1'b0;
            b = BW'($urandom);
         end
         req_data[i*DATA_W +: DATA_W] = b[DATA_W-1:0];
         req_last[i] = b[DATA_W];
      end
      tx_ready = ($urandom_range(99) < txprob);
   endtask

   task automatic sample();
      int unsigned   e;
      logic [BW-1:0] b;
      @(negedge clk);
      s_rr = req_ready;
      s_tv = tx_valid;
      s_td = tx_data;
      s_en = uart_en;
      s_hs = tx_valid && tx_ready;
      acc  = req_valid & req_ready;
      if (!rst_n) begin
         chk_eq("reset_outputs", {req_ready, tx_valid, tx_data, uart_en, busy, grant_id}, 0);
         m_rr = NUM_REQ - 1;
         m_owner = 0;
         m_lock = 1'b0;
         sb.delete();
         pend_lat = 1'b0;
         stall_prev = 1'b0;
         rr_prev = '0;
         acc = '0;
         s_hs = 1'b0;
      end else begin
         if (pend_lat) chk_eq("accept_to_tx_valid", tx_valid, 1);
         if (stall_prev) begin
            chk_eq("tx_valid_hold", tx_valid, 1);
            chk_eq("tx_data_hold", tx_data, td_prev);
         end
         if (rr_prev != 0) chk_eq("ready_one_cycle", req_ready, 0);
         chk_eq("busy_eq_en", busy, uart_en);
         if (!uart_en) chk_eq("off_no_tx_valid", tx_valid, 0);
         if (req_ready != 0) begin
            chk_eq("ready_needs_valid", req_ready & ~req_valid, 0);
            chk_eq("ready_not_in_xfer", tx_valid, 0);
            chk_eq("ready_needs_en", uart_en, 1);
            e = pick(req_valid);
            chk_eq("grant_choice", req_ready, 32'(1) << e);
            chk_eq("one_byte_in_flight", sb.size(), 0);
            sb.push_back({req_last[e], req_data[e*DATA_W +: DATA_W]});
            acc_ids.push_back(e);
            m_rr = e;
            m_owner = e;
         end
         if (s_hs) begin
            if (sb.size() == 0) begin
               chk_eq("tx_without_accept", sb.size(), 1);
            end else begin
               b = sb.pop_front();
               chk_eq("tx_data", tx_data, b[DATA_W-1:0]);
               chk_eq("grant_id", grant_id, m_owner);
               m_lock = !b[DATA_W];
               n_sent++;
            end
         end
         pend_lat = (req_ready != 0);
         stall_prev = tx_valid && !tx_ready;
         td_prev = tx_data;
         rr_prev = req_ready;
      end
   endtask

   task automatic cycle();
      drive();
      sample();
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc[i]) src_pos[i]++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      src_clear();
      repeat (3) cycle();
      rst_n = 1'b1;
   endtask

   task automatic run_until_sent(input string tag, input int target, input int budget);
      int t = 0;
      while (n_sent < target && t < budget) begin
         cycle();
         t++;
      end
      chk_eq(tag, n_sent, target);
   endtask

   task automatic wait_hs(input string tag, input int budget);
      int t = 0;
      do begin
         cycle();
         t++;
      end while (!s_hs && t < budget);
      chk_eq(tag, s_hs, 1);
   endtask

   task automatic wait_acc(input string tag, input int budget);
      int t = 0;
      do begin
         cycle();
         t++;
      end while (acc == 0 && t < budget);
      chk_eq(tag, acc != 0, 1);
   endtask

   initial begin
      int t_en, t_tv, pulses, hs_cnt, low_cnt, off_at, base, sbase;
      int unsigned exp_ord[$];

      src_clear();
      #1;
      do_reset();
      repeat (3) begin
         cycle();
         chk_eq("idle_after_reset", {s_en, s_tv, s_rr}, 0);
      end

      // Single byte from requester 0, timed from uart_en rising.
      src_push(0, 8'hA5, 1'b1);
      t_en = -1;
      t_tv = -1;
      pulses = 0;
      for (int t = 0; t < 40; t++) begin
         cycle();
         if (s_en && t_en < 0) t_en = t;
         if (s_tv && t_tv < 0) begin
            t_tv = t;
            chk_eq("t1_tx_data", s_td, 8'hA5);
         end
         if (s_rr[0]) pulses++;
      end
      chk_eq("t1_warmup_latency", t_tv - t_en, WARMUP_CYC + 1);
      chk_eq("t1_ready_pulses", pulses, 1);

      // All four valid, single-byte packets.
      do_reset();
      base = acc_ids.size();
      src_push(0, 8'h10, 1'b1);
      src_push(0, 8'h14, 1'b1);
      src_push(1, 8'h11, 1'b1);
      src_push(2, 8'h12, 1'b1);
      src_push(3, 8'h13, 1'b1);
      run_until_sent("t2_done", n_sent + 5, 200);
      exp_ord = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) chk_eq("t2_order", acc_ids[base+k], exp_ord[k]);

      // Locked 3-byte packet from requester 1 with 0 and 2 competing.
      src_clear();
      base = acc_ids.size();
      src_push(1, 8'h21, 1'b0);
      src_push(1, 8'h22, 1'b0);
      src_push(1, 8'h23, 1'b1);
      src_push(0, 8'h20, 1'b1);
      src_push(2, 8'h24, 1'b1);
      run_until_sent("t3_done", n_sent + 5, 200);
      exp_ord = '{1, 1, 1, 2, 0};
      for (int k = 0; k < 5; k++) chk_eq("t3_order", acc_ids[base+k], exp_ord[k]);

      // Transmitter stall for 50 cycles.
      src_clear();
      base = acc_ids.size();
      sbase = n_sent;
      src_push(1, 8'h77, 1'b1);
      src_push(0, 8'h5A, 1'b1);
      txprob = 0;
      wait_acc("t4_accept", 40);
      chk_eq("t4_first_grant", acc_ids[base], 1);
      pulses = 0;
      hs_cnt = 0;
      for (int t = 0; t < 50; t++) begin
         cycle();
         if (s_rr != 0) pulses++;
         if (s_hs) hs_cnt++;
      end
      chk_eq("t4_no_ready_in_stall", pulses, 0);
      chk_eq("t4_no_hs_in_stall", hs_cnt, 0);
      chk_eq("t4_held_data", s_td, 8'h77);
      txprob = 100;
      cycle();
      chk_eq("t4_release_hs", s_hs, 1);
      chk_eq("t4_one_transfer", n_sent, sbase + 1);
      run_until_sent("t4_done", sbase + 2, 50);

      // Idle shut-off, then a grant in the last idle cycle.
      src_clear();
      src_push(2, 8'h31, 1'b1);
      wait_hs("t5_hs_a", 50);
      off_at = -1;
      for (int t = 1; t <= 40; t++) begin
         cycle();
         if (!s_en && off_at < 0) off_at = t;
      end
      chk_eq("t5_off_delay", off_at, IDLE_CYC + 1);
      src_push(3, 8'h32, 1'b1);
      wait_hs("t5_hs_b", 50);
      low_cnt = 0;
      for (int t = 1; t < IDLE_CYC; t++) begin
         cycle();
         if (!s_en) low_cnt++;
      end
      chk_eq("t5_en_during_idle", low_cnt, 0);
      src_push(0, 8'h33, 1'b1);
      cycle();
      chk_eq("t5_late_grant", s_rr, 4'b0001);
      cycle();
      chk_eq("t5_en_kept", s_en, 1);
      chk_eq("t5_late_tx_valid", s_tv, 1);

      // Lock holds off others and suppresses idle shut-off.
      src_clear();
      base = acc_ids.size();
      sbase = n_sent;
      src_push(2, 8'h41, 1'b0);
      wait_hs("t5b_hs", 50);
      src_push(3, 8'h43, 1'b1);
      pulses = 0;
      low_cnt = 0;
      for (int t = 0; t < 40; t++) begin
         cycle();
         if (s_rr != 0) pulses++;
         if (!s_en) low_cnt++;
      end
      chk_eq("t5b_locked_out", pulses, 0);
      chk_eq("t5b_en_while_locked", low_cnt, 0);
      src_push(2, 8'h42, 1'b1);
      run_until_sent("t5b_done", sbase + 3, 60);
      exp_ord = '{2, 2, 3};
      for (int k = 0; k < 3; k++) chk_eq("t5b_order", acc_ids[base+k], exp_ord[k]);

      // Asynchronous reset while 0x3C waits in XFER.
      src_clear();
      src_push(0, 8'h3C, 1'b1);
      txprob = 0;
      wait_acc("t6_accept", 40);
      cycle();
      chk_eq("t6_in_xfer", s_tv, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("t6_async_drop", {tx_valid, uart_en, busy}, 0);
      src_clear();
      repeat (2) cycle();
      rst_n = 1'b1;
      txprob = 100;
      hs_cnt = 0;
      for (int t = 0; t < 30; t++) begin
         cycle();
         if (s_tv) hs_cnt++;
      end
      chk_eq("t6_byte_discarded", hs_cnt, 0);

      // Randomized packets on all requesters.
      do_reset();
      vprob = 60;
      txprob = 70;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < 12; j++) begin
            src_push(i, DATA_W'($urandom), (j == 11) || ($urandom_range(2) == 0));
         end
      end
      run_until_sent("rand_done", n_sent + 12 * NUM_REQ, 6000);
      chk_eq("rand_sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
